// File: rtl/mem_loader.sv
// mem_loader: receives a framed byte stream and writes its payload as 64-bit
// words into port b of a data memory.
//
// Frame: 0xA5, count_hi, count_lo, 8*N data bytes, checksum (XOR of the data
// bytes). N = {count_hi, count_lo} must lie in 1 .. 2^ADDR_W.
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   rst_n    asynchronous active-low reset
//   rx_data  received byte
//   rx_valid one-cycle strobe qualifying rx_data
//   enb/web  memory port-b enable / write enable (always equal, write only)
//   addrb    memory port-b word address
//   dinb     memory port-b write data
//   busy     high while a frame is in progress
//   done     one-cycle pulse when a frame ends (good, bad or timed out)
//   err      error flag for the last frame, held until the next sync byte
module mem_loader #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              enb,
  output logic              web,
  output logic [ADDR_W-1:0] addrb,
  output logic [63:0]       dinb,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Wide enough to compare the 16-bit count against 2^ADDR_W without overflow.
  localparam int CW = ((ADDR_W > 16) ? ADDR_W : 16) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM} state_t;

  state_t              state, state_d;
  logic [7:0]          len_hi;
  logic [15:0]         n_len;
  logic [15:0]         n_in;
  logic [2:0]          byte_cnt;
  logic [ADDR_W-1:0]   word_idx;
  logic [63:0]         asm_word;
  logic [7:0]          csum;
  logic [TW-1:0]       tmo_cnt;
  logic                tmo_hit;
  logic                len_ok;
  logic                word_end;
  logic                last_word;

  assign n_in      = {len_hi, rx_data};
  assign len_ok    = (n_in != 16'd0) && (CW'(n_in) <= (CW'(1) << ADDR_W));
  assign word_end  = (state == DATA) && rx_valid && (byte_cnt == 3'd7);
  assign last_word = (CW'(word_idx) + CW'(1)) == CW'(n_len);
  // Fires on the TIMEOUT-th consecutive cycle without a byte.
  assign tmo_hit   = (state != IDLE) && !rx_valid && (tmo_cnt == TW'(TIMEOUT - 1));
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (rx_valid && rx_data == 8'hA5) state_d = LEN_HI;
      LEN_HI:  if (rx_valid) state_d = LEN_LO;
      LEN_LO:  if (rx_valid) state_d = len_ok ? DATA : IDLE;
      DATA:    if (word_end && last_word) state_d = CSUM;
      CSUM:    if (rx_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_hit) state_d = IDLE;
  end

  // Datapath, memory strobes and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enb      <= 1'b0;
      web      <= 1'b0;
      addrb    <= '0;
      dinb     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      len_hi   <= '0;
      n_len    <= '0;
      byte_cnt <= '0;
      word_idx <= '0;
      asm_word <= '0;
      csum     <= '0;
      tmo_cnt  <= '0;
    end else begin
      enb  <= 1'b0;
      web  <= 1'b0;
      done <= 1'b0;

      if (state == IDLE || rx_valid || tmo_hit) tmo_cnt <= '0;
      else                                      tmo_cnt <= tmo_cnt + TW'(1);

      if (rx_valid) begin
        unique case (state)
          IDLE: if (rx_data == 8'hA5) begin
            err      <= 1'b0;
            word_idx <= '0;
            byte_cnt <= '0;
            csum     <= '0;
          end
          LEN_HI: len_hi <= rx_data;
          LEN_LO: begin
            n_len <= n_in;
            if (!len_ok) begin
              err  <= 1'b1;
              done <= 1'b1;
            end
          end
          DATA: begin
            // Big-endian assembly: the first byte of a word ends up in [63:56].
            asm_word <= {asm_word[55:0], rx_data};
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd7) begin
              dinb     <= {asm_word[55:0], rx_data};
              enb      <= 1'b1;
              web      <= 1'b1;
              addrb    <= word_idx;
              word_idx <= word_idx + ADDR_W'(1);
            end
          end
          CSUM: begin
            done <= 1'b1;
            err  <= (rx_data != csum);
          end
          default: ;
        endcase
      end

      // A timed-out frame is dropped; any partially assembled word is never written.
      if (tmo_hit) begin
        err  <= 1'b1;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
module tb_mem_loader;
  localparam int ADDR_W  = 14;
  localparam int TIMEOUT = 40;

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              enb, web, busy, done, err;
  logic [ADDR_W-1:0] addrb;
  logic [63:0]       dinb;

  mem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: frame bytes collected since the sync byte, outputs
  // derived from the frame's length and contents.
  logic [7:0]  fb[$];
  bit          active;
  int          mn;
  int          idle_cnt;
  logic        exp_enb, exp_done, exp_err, exp_busy;
  logic [63:0] exp_dinb;
  int          exp_addr;

  task automatic model_reset();
    fb.delete();
    active = 0; mn = 0; idle_cnt = 0;
    exp_enb = 0; exp_done = 0; exp_err = 0; exp_busy = 0;
    exp_dinb = 0; exp_addr = 0;
  endtask

  task automatic end_frame();
    active = 0;
    fb.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    int L;
    logic [7:0] x;
    logic [63:0] w;
    exp_enb = 0; exp_done = 0;
    if (!active) begin
      if (v && d == 8'hA5) begin
        fb.delete(); fb.push_back(d);
        active = 1; exp_err = 0; idle_cnt = 0;
      end
    end else if (!v) begin
      idle_cnt++;
      if (idle_cnt == TIMEOUT) begin
        exp_err = 1; exp_done = 1; end_frame();
      end
    end else begin
      idle_cnt = 0;
      fb.push_back(d);
      L = fb.size();
      if (L == 3) begin
        mn = {fb[1], fb[2]};
        if (mn == 0 || mn > (1 << ADDR_W)) begin
          exp_err = 1; exp_done = 1; end_frame();
        end
      end else if (L > 3 && L <= 3 + 8*mn) begin
        if ((L - 3) % 8 == 0) begin
          w = 0;
          for (int i = 0; i < 8; i++) w = {w[55:0], fb[L-8+i]};
          exp_enb = 1; exp_addr = (L - 3) / 8 - 1; exp_dinb = w;
        end
      end else if (L == 4 + 8*mn) begin
        x = 0;
        for (int i = 3; i < L - 1; i++) x = x ^ fb[i];
        exp_err = (d != x); exp_done = 1; end_frame();
      end
    end
    exp_busy = active;
  endtask

  // Per-cycle comparison against the model, plus write/done bookkeeping.
  bit          chk_on = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          last_wr_cyc = 0, prev_wr_cyc = 0;
  logic [63:0] last_dinb;
  logic [ADDR_W-1:0] last_addr;
  bit          done_seen;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && chk_on) begin
        chk("enb", enb, exp_enb);
        chk("web", web, exp_enb);
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("err", err, exp_err);
        if (exp_enb) begin
          chk("addrb", addrb, exp_addr);
          chk("dinb", dinb, exp_dinb);
        end
      end
      if (enb) begin
        wr_count++;
        last_addr = addrb;
        last_dinb = dinb;
        prev_wr_cyc = last_wr_cyc;
        last_wr_cyc = cyc;
      end
      if (done) done_seen = 1;
    end
  end

  task automatic cycle(input logic v, input logic [7:0] d);
    rx_valid = v; rx_data = d;
    @(posedge clk);
    if (rst_n) model_step(v, d);
    else       model_reset();
    @(negedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cycle(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic send_list(input logic [7:0] bl[$]);
    foreach (bl[i]) send(bl[i]);
  endtask

  task automatic frame_032(input logic [7:0] cs);
    logic [7:0] bl[$];
    bl = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    bl.push_back(cs);
    send_list(bl);
  endtask

  task automatic rand_frame();
    int kind, n, gap;
    logic [7:0] b, x;
    if ($urandom_range(0, 3) == 0) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      send(b);
    end
    kind = $urandom_range(0, 9);
    send(8'hA5);
    if (kind == 0) begin send(8'h00); send(8'h00); idle(2); return; end
    if (kind == 1) begin
      n = (1 << ADDR_W) + $urandom_range(1, 200);
      send(8'(n >> 8)); send(8'(n)); idle(2); return;
    end
    n = $urandom_range(1, 4);
    send(8'(n >> 8)); send(8'(n));
    x = 0;
    for (int i = 0; i < 8*n; i++) begin
      if (kind == 2 && i == 8*n - 3) begin idle(TIMEOUT + 2); return; end
      b = 8'($urandom);
      x = x ^ b;
      send(b);
      if ($urandom_range(0, 3) == 0) begin
        gap = $urandom_range(1, 3);
        idle(gap);
      end
    end
    if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
    send(x);
    idle($urandom_range(0, 2));
  endtask

  initial begin
    int w0;
    logic [7:0] bl[$];
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    done_seen = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_enb", enb, 0);
    chk("rst_web", web, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_dinb", dinb, 0);
    rst_n = 1'b1;
    chk_on = 1;
    idle(2);

    // Single-word frame with good checksum.
    w0 = wr_count; done_seen = 0;
    frame_032(8'h88); idle(2);
    chk("t32_writes", wr_count - w0, 1);
    chk("t32_addr", last_addr, 0);
    chk("t32_data", last_dinb, 64'h1122334455667788);
    chk("t32_err", err, 0);
    chk("t32_done", done_seen, 1);

    // Two words, back-to-back bytes; checksum of 01..10 is 0x10.
    w0 = wr_count; done_seen = 0;
    bl = '{8'hA5, 8'h00, 8'h02};
    for (int i = 1; i <= 16; i++) bl.push_back(8'(i));
    bl.push_back(8'h10);
    send_list(bl); idle(2);
    chk("t33_writes", wr_count - w0, 2);
    chk("t33_spacing", last_wr_cyc - prev_wr_cyc, 8);
    chk("t33_addr", last_addr, 1);
    chk("t33_data", last_dinb, 64'h090A0B0C0D0E0F10);
    chk("t33_err", err, 0);

    // Bad checksum: word still written, err raised.
    w0 = wr_count; done_seen = 0;
    frame_032(8'h00); idle(2);
    chk("t34_writes", wr_count - w0, 1);
    chk("t34_data", last_dinb, 64'h1122334455667788);
    chk("t34_err", err, 1);
    chk("t34_done", done_seen, 1);

    // Zero length.
    w0 = wr_count; done_seen = 0;
    send(8'hA5); send(8'h00); send(8'h00); idle(2);
    chk("t35_writes", wr_count - w0, 0);
    chk("t35_err", err, 1);
    chk("t35_busy", busy, 0);
    chk("t35_done", done_seen, 1);
    frame_032(8'h88); idle(2);
    chk("t35_err_clr", err, 0);

    // Length above 2^ADDR_W.
    w0 = wr_count;
    send(8'hA5); send(8'h40); send(8'h01); idle(2);
    chk("len_big_writes", wr_count - w0, 0);
    chk("len_big_err", err, 1);

    // Timeout after three data bytes.
    w0 = wr_count; done_seen = 0;
    bl = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33};
    send_list(bl); idle(TIMEOUT + 3);
    chk("t36_writes", wr_count - w0, 0);
    chk("t36_err", err, 1);
    chk("t36_busy", busy, 0);
    chk("t36_done", done_seen, 1);

    // Asynchronous reset mid-frame.
    bl = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_list(bl);
    #2 rst_n = 1'b0;
    #1;
    chk("t37_enb", enb, 0);
    chk("t37_busy", busy, 0);
    chk("t37_done", done, 0);
    chk("t37_err", err, 0);
    chk("t37_addrb", addrb, 0);
    chk("t37_dinb", dinb, 0);
    w0 = wr_count;
    idle(2);
    rst_n = 1'b1;
    frame_032(8'h88); idle(2);
    chk("t37_writes", wr_count - w0, 1);
    chk("t37_addr", last_addr, 0);
    chk("t37_data", last_dinb, 64'h1122334455667788);
    chk("t37_err2", err, 0);

    // Randomized frames against the model.
    for (int f = 0; f < 60; f++) rand_frame();
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter: ADDR_W, 14, word address width of data memory port b.
REQ-002 Parameter: TIMEOUT, 1000000, max clk cycles allowed between two bytes inside a frame.
REQ-003 Port: clk  input  1  100 MHz system clock; single clock domain; all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: rx_data  input  8  received byte from the serial receiver.
REQ-006 Port: rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-007 Port: enb  output  1  memory port-b enable.
REQ-008 Port: web  output  1  memory port-b write enable.
REQ-009 Port: addrb  output  ADDR_W  memory port-b word address.
REQ-010 Port: dinb  output  64  memory port-b write data.
REQ-011 Port: busy  output  1  high while a frame is in progress.
REQ-012 Port: done  output  1  one-cycle pulse at end of frame.
REQ-013 Port: err  output  1  sticky error flag for the last frame.

Function
REQ-014 Frame format SHALL be: sync 0xA5, count_hi, count_lo, then 8*N data bytes, then 1 checksum byte; N = {count_hi,count_lo}.
REQ-015 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA, CSUM.
REQ-016 IDLE: rx_valid with 0xA5 -> LEN_HI, clear err, clear word index and checksum; other bytes ignored.
REQ-017 LEN_HI -> LEN_LO on next byte; LEN_LO -> DATA on next byte if 1 <= N <= 2^ADDR_W.
REQ-018 N = 0 or N > 2^ADDR_W: set err, pulse done, return to IDLE, no memory write.
REQ-019 DATA: bytes shift into 64-bit assembly register big-endian; first byte of each word lands in bits [63:56].
REQ-020 On the 8th byte of a word, word SHALL be latched into dinb and enb=web=1 for exactly the next cycle with addrb = word index (0 for first word).
REQ-021 Word index SHALL increment after each write; after word N-1 FSM -> CSUM.
REQ-022 rx_valid on consecutive cycles SHALL be accepted without loss, including the byte arriving in the write-strobe cycle.
REQ-023 Checksum SHALL be XOR of all 8*N data bytes (header excluded).
REQ-024 CSUM: on byte arrival pulse done next cycle; err=1 if byte differs from computed checksum; -> IDLE.
REQ-025 Timeout: in any non-IDLE state, TIMEOUT cycles with no rx_valid SHALL set err, pulse done, return to IDLE; a partially assembled word SHALL NOT be written.
REQ-026 Words already written before a checksum error or timeout SHALL remain in memory (no rollback).
REQ-027 busy = 1 in every state except IDLE.
REQ-028 enb and web SHALL always be equal; memory is never read by this block.
REQ-029 err SHALL hold until the next sync byte is accepted in IDLE.

Reset
REQ-030 rst_n low SHALL immediately force IDLE; enb=0, web=0, addrb=0, dinb=0, busy=0, done=0, err=0, counters and checksum cleared.
REQ-031 Reset mid-frame SHALL abandon the frame without any further write; next 0xA5 after release starts a new frame.

Verification
REQ-032 Bytes A5 00 01 11 22 33 44 55 66 77 88 88 -> one write addr 0 dinb 0x1122334455667788, done pulse, err=0.
REQ-033 N=2, 16 data bytes on consecutive cycles -> writes to addr 0 then addr 1 exactly 8 cycles apart, correct data, no byte lost.
REQ-034 Same as REQ-032 with checksum 0x00 -> write at addr 0 still occurs, done pulse, err=1.
REQ-035 Bytes A5 00 00 -> no write, done pulse, err=1, busy=0; following valid frame clears err.
REQ-036 A5 00 01 + 3 data bytes, then idle TIMEOUT cycles -> no write, err=1, done pulse, FSM IDLE.
REQ-037 rst_n low after 5 data bytes -> all outputs zero asynchronously; a full frame after release writes correctly to addr 0.
